e_candidate_gen: RTL and testbench

E_CANDIDATE_GEN -- requirements
Module: e_candidate_gen

---
 rtl/rsa_pkg.sv | 38 +++
 rtl/rsa_lfsr32.sv | 20 ++
 rtl/e_candidate_gen.sv | 116 +++++++++++
 tb/tb_e_candidate_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA key-generation datapath:
// FSM state encoding, LFSR polynomial, and the smallest public exponent.
package rsa_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [WORD_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [WORD_W-1:0] E_MIN     = 32'd3;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    FILTER,
    ISSUE,
    WAIT,
    DONE,
    FAIL
  } state_t;

  // One Galois right-shift step for taps 32,22,2,1; a nonzero state stays nonzero.
  function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
  endfunction

  // All ones from bit 0 up to the most significant set bit of x.
  function automatic logic [WORD_W-1:0] msb_mask(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] m;
    m = x;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rsa_lfsr32.sv
// 32-bit Galois LFSR that advances only when en is high; a zero seed is forced to 1.
module rsa_lfsr32
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] seed,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= (seed == '0) ? WORD_W'(1) : seed;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/e_candidate_gen.sv
// Public-exponent candidate generator: draws odd values below phi and hands them to a GCD checker.
// Build option RSA_RETRY_LIMIT_EN caps the number of candidates per request at MAX_RETRIES.
module e_candidate_gen
  import rsa_pkg::*;
#(
  parameter logic [WORD_W-1:0] SEED        = 32'hACE1_2468,
  parameter int unsigned       MAX_RETRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen,
  input  logic [WORD_W-1:0] phi,
  input  logic              should_redo,
  input  logic              valid,
  output logic              start,
  output logic [WORD_W-1:0] rng_e,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  attempts
);

`ifdef RSA_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT = 1'b1;
`else
  localparam bit RETRY_LIMIT = 1'b0;
`endif

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] phi_r;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] cand;
  logic [WORD_W-1:0] lfsr_q;
  logic              cand_ok;
  logic              retry_hit;
  logic              restart;

  rsa_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (state == DRAW),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign cand_ok   = (cand >= E_MIN) && (cand < phi_r);
  assign retry_hit = RETRY_LIMIT && (attempts == CNT_W'(MAX_RETRIES));
  assign restart   = gen && ((state == IDLE) || (state == DONE) || (state == FAIL));
  assign start     = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; gen is honoured only from the resting states.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, FAIL: begin
        if (gen) begin
          state_next = (phi < WORD_W'(4)) ? FAIL : DRAW;
        end
      end
      DRAW:   state_next = FILTER;
      FILTER: state_next = cand_ok ? ISSUE : DRAW;
      ISSUE:  state_next = WAIT;
      WAIT: begin
        if (valid) begin
          state_next = DONE;
        end else if (should_redo) begin
          state_next = retry_hit ? FAIL : DRAW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi_r    <= '0;
      mask     <= '0;
      cand     <= '0;
      rng_e    <= '0;
      attempts <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      busy <= (state_next == DRAW) || (state_next == FILTER) ||
              (state_next == ISSUE) || (state_next == WAIT);
      done <= (state_next == DONE);
      fail <= (state_next == FAIL);
      if (restart) begin
        phi_r    <= phi;
        mask     <= msb_mask(phi);
        attempts <= '0;
      end
      if (state == DRAW) begin
        cand <= (lfsr_step(lfsr_q) & mask) | WORD_W'(1);
      end
      if ((state == FILTER) && cand_ok) begin
        rng_e <= cand;
      end
      if ((state == ISSUE) && (attempts != '1)) begin
        attempts <= attempts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_e_candidate_gen.sv
// Randomized bench for e_candidate_gen with a draw-level reference model of the candidate stream.
module tb_e_candidate_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int          MAXR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gen = 1'b0;
  logic [31:0] phi = '0;
  logic        should_redo = 1'b0;
  logic        valid = 1'b0;
  logic        start;
  logic [31:0] rng_e;
  logic        busy;
  logic        done;
  logic        fail;
  logic [7:0]  attempts;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_lfsr;
  logic [31:0] first_after_por;
  logic [31:0] first_after_rst;

  e_candidate_gen #(.SEED(SEED), .MAX_RETRIES(MAXR)) dut (
    .clk         (clk),
    .rst         (rst),
    .gen         (gen),
    .phi         (phi),
    .should_redo (should_redo),
    .valid       (valid),
    .start       (start),
    .rng_e       (rng_e),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .attempts    (attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Multiplication by x^-1 modulo the feedback polynomial.
  function automatic logic [31:0] model_next(input logic [31:0] x);
    if (x[0]) return (x >> 1) ^ 32'h8020_0003;
    return x >> 1;
  endfunction

  function automatic logic [31:0] model_mask(input logic [31:0] p);
    longint m;
    m = 1;
    while (m <= longint'(p)) m = m * 2;
    return 32'(m - 1);
  endfunction

  // Next accepted candidate, and the cycles it costs (two per draw).
  task automatic model_draw(input logic [31:0] p, output logic [31:0] c, output int lat);
    logic [31:0] mk;
    mk  = model_mask(p);
    lat = 0;
    do begin
      m_lfsr = model_next(m_lfsr);
      c      = (m_lfsr & mk) | 32'd1;
      lat   += 2;
    end while (!(c >= 32'd3 && c < p));
  endtask

  task automatic await_start(input string tag, input int lat);
    int n;
    n = 0;
    while (start !== 1'b1 && n < lat + 8) begin
      step();
      n++;
    end
    check($sformatf("%s latency", tag), 32'(n), 32'(lat));
  endtask

  task automatic pulse_gen(input logic [31:0] p);
    gen = 1'b1;
    phi = p;
    step();
    gen = 1'b0;
    phi = $urandom;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int extra;
    extra = 0;
    repeat (cycles) begin
      step();
      if (start === 1'b1) extra++;
    end
    check($sformatf("%s extra starts", tag), 32'(extra), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check($sformatf("%s start", tag), 32'(start), 32'd0);
    check($sformatf("%s rng_e", tag), rng_e, 32'd0);
    check($sformatf("%s attempts", tag), 32'(attempts), 32'd0);
    check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s done", tag), 32'(done), 32'd0);
    check($sformatf("%s fail", tag), 32'(fail), 32'd0);
  endtask

  // One request: n_redo rejections, then acceptance (optionally with a coincident redo).
  task automatic run_request(input string tag, input logic [31:0] p, input int n_redo,
                             input bit both, output logic [31:0] first_c);
    logic [31:0] c;
    int          lat;
    int          d;
    pulse_gen(p);
    check($sformatf("%s busy after gen", tag), 32'(busy), 32'd1);
    for (int a = 1; a <= n_redo + 1; a++) begin
      model_draw(p, c, lat);
      if (a == 1) first_c = c;
      await_start($sformatf("%s try%0d", tag, a), lat);
      check($sformatf("%s try%0d rng_e", tag, a), rng_e, c);
      step();
      check($sformatf("%s try%0d attempts", tag, a), 32'(attempts), 32'(a));
      d = $urandom_range(0, 3);
      repeat (d) begin
        gen = $urandom_range(0, 1);
        phi = $urandom;
        step();
        gen = 1'b0;
      end
      check($sformatf("%s try%0d rng_e held", tag, a), rng_e, c);
      check($sformatf("%s try%0d no restart", tag, a), 32'(start), 32'd0);
      if (a <= n_redo) begin
        should_redo = 1'b1;
        step();
        should_redo = 1'b0;
      end else begin
        valid = 1'b1;
        should_redo = both;
        step();
        valid = 1'b0;
        should_redo = 1'b0;
      end
    end
    check($sformatf("%s done", tag), 32'(done), 32'd1);
    check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s fail", tag), 32'(fail), 32'd0);
    check($sformatf("%s attempts", tag), 32'(attempts), 32'(n_redo + 1));
    check($sformatf("%s key", tag), rng_e, c);
    expect_quiet(tag, 3);
    check($sformatf("%s done held", tag), 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] p;
    int          lat;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_cleared("por");
    m_lfsr = SEED;
    expect_quiet("por idle", 4);

    run_request("phi100", 32'd100, 0, 1'b0, first_after_por);
    run_request("single", 32'd3120, 0, 1'b0, c);
    run_request("redo2", 32'd3120, 2, 1'b0, c);
    run_request("both", 32'd3120, 1, 1'b1, c);

    for (int i = 0; i < 4; i++) begin
      pulse_gen(32'(i));
      check($sformatf("small%0d fail", i), 32'(fail), 32'd1);
      check($sformatf("small%0d busy", i), 32'(busy), 32'd0);
      check($sformatf("small%0d start", i), 32'(start), 32'd0);
      expect_quiet($sformatf("small%0d", i), 3);
    end

    run_request("from_fail", 32'd5000, 1, 1'b0, c);

`ifdef RSA_RETRY_LIMIT_EN
    pulse_gen(32'd3120);
    for (int a = 1; a <= MAXR; a++) begin
      model_draw(32'd3120, c, lat);
      await_start($sformatf("limit try%0d", a), lat);
      check($sformatf("limit try%0d rng_e", a), rng_e, c);
      step();
      check($sformatf("limit try%0d attempts", a), 32'(attempts), 32'(a));
      should_redo = 1'b1;
      step();
      should_redo = 1'b0;
    end
    check("limit fail", 32'(fail), 32'd1);
    check("limit busy", 32'(busy), 32'd0);
    expect_quiet("limit", 6);
`else
    run_request("unbounded", 32'd3120, MAXR + 2, 1'b0, c);
`endif

    for (int i = 0; i < 20; i++) begin
      p = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(16, 400)) : ($urandom | 32'h10);
      run_request($sformatf("rand%0d", i), p, $urandom_range(0, 3), 1'($urandom_range(0, 1)), c);
    end

    pulse_gen(32'd3120);
    model_draw(32'd3120, c, lat);
    await_start("pre_rst", lat);
    step();
    rst = 1'b1;
    valid = 1'b1;
    step();
    rst = 1'b0;
    valid = 1'b0;
    check_cleared("mid_rst");
    m_lfsr = SEED;
    expect_quiet("post_rst idle", 5);
    run_request("post_rst", 32'd100, 0, 1'b0, first_after_rst);
    check("post_rst first cand", first_after_rst, first_after_por);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
